// File: rtl/riscv_core_config_pkg.sv
// Core configuration defaults feeding the parameters of the fetch unit.
package riscv_core_config_pkg;

  localparam int unsigned PREFETCH_DEPTH           = 4;
  localparam int unsigned PREFETCH_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/riscv_core_types_pkg.sv
// Core-wide datapath types shared by the fetch path and its consumers.
package riscv_core_types_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // One fetched instruction together with its PC and access-fault flag.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with clear; power-of-two depth, registered head output.
module riscv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; clear wins over push and pop.
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Control state: pointers and count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; data is never reset, validity comes from the count.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/riscv_prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited sequential fetch, in-order
// response queue, and redirect handling that discards in-flight responses.
module riscv_prefetch_buffer
  import riscv_core_config_pkg::*;
  import riscv_core_types_pkg::*;
#(
  parameter int unsigned          DEPTH           = PREFETCH_DEPTH,
  parameter int unsigned          MAX_OUTSTANDING = PREFETCH_MAX_OUTSTANDING,
  parameter int unsigned          ADDR_WIDTH      = XLEN,
  parameter int unsigned          DATA_WIDTH      = ILEN,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_err_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_err_o
);

  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  err;
  } entry_t;

  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [OUT_W-1:0]      drop_q, drop_d;
  logic [OUT_W-1:0]      out_step;
  logic [ADDR_WIDTH-1:0] flush_target;
  logic [SUM_W-1:0]      credit_sum;
  logic                  req_fire, rsp_keep, rsp_drop;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  entry_t                push_entry, head_entry;
  logic [ENTRY_W-1:0]    head_bits;

  // Request issue: one credit per free queue slot, none while draining
  // stale responses or during a redirect; gated until reset has released.
  always_comb begin
    credit_sum      = SUM_W'(fifo_count) + SUM_W'(out_q);
    mem_req_valid_o = en_q && !flush_i && (drop_q == '0)
                      && (out_q < OUT_W'(MAX_OUTSTANDING))
                      && (credit_sum < SUM_W'(DEPTH));
  end

  // Next state for PCs, outstanding and drop counters.
  always_comb begin
    req_fire     = mem_req_valid_o && mem_req_ready_i;
    rsp_keep     = mem_rsp_valid_i && (drop_q == '0);
    rsp_drop     = mem_rsp_valid_i && (drop_q != '0);
    flush_target = flush_pc_i & ~ADDR_WIDTH'(3);
    out_step     = out_q;
    if (req_fire && !mem_rsp_valid_i)      out_step = out_q + OUT_W'(1);
    else if (!req_fire && mem_rsp_valid_i) out_step = out_q - OUT_W'(1);
    en_d     = 1'b1;
    out_d    = out_step;
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    if (flush_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      req_pc_d = flush_target;
      rsp_pc_d = flush_target;
      drop_d   = out_step;
    end else begin
      if (req_fire) req_pc_d = req_pc_q + ADDR_WIDTH'(4);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(4);
      if (rsp_drop) drop_d   = drop_q - OUT_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      req_pc_q <= RESET_VECTOR;
      rsp_pc_q <= RESET_VECTOR;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      en_q     <= en_d;
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  assign mem_req_addr_o = req_pc_q;

  assign push_entry = '{instr: mem_rsp_data_i, pc: rsp_pc_q, err: mem_rsp_err_i};
  assign fifo_push  = rsp_keep && !flush_i;
  assign fifo_pop   = instr_valid_o && instr_ready_i;

  riscv_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_bits),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Head presentation; zeros when the queue is empty.
  always_comb begin
    head_entry    = head_bits;
    instr_valid_o = !fifo_empty;
    instr_o       = instr_valid_o ? head_entry.instr : '0;
    instr_pc_o    = instr_valid_o ? head_entry.pc    : '0;
    instr_err_o   = instr_valid_o ? head_entry.err   : 1'b0;
  end

endmodule

// File: tb/tb_riscv_prefetch_buffer.sv
// Scoreboard bench for riscv_prefetch_buffer: randomised memory and decode
// handshakes against a sequential-PC reference stream.
module tb_riscv_prefetch_buffer;
  import riscv_core_types_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_err_o;

  riscv_prefetch_buffer #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .RESET_VECTOR(RV)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_err_o(instr_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t        pend[$];
  fetch_entry_t exp_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int rdy_pct = 100, irdy_pct = 100, lat_min = 1, lat_max = 1;
  int accepts = 0, pops = 0, rel_cnt = 0;
  logic [31:0] exp_req, exp_tail, last_acc;
  bit restart = 0, prev_vld = 0, rst_prev_low = 1, prev_flush_m = 0;
  bit saw_wrap = 0, flushed_now = 0;

  // Memory image and fault map used by both memory model and reference.
  function automatic bit err_of(input logic [31:0] pc);
    return (pc == 32'h4) || (pc[7:2] == 6'd37);
  endfunction

  function automatic fetch_entry_t model_entry(input logic [31:0] pc);
    fetch_entry_t e;
    e.instr = pc ^ KEY;
    e.pc    = pc;
    e.err   = err_of(pc);
    return e;
  endfunction

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic redirect_model(input logic [31:0] pc);
    exp_q.delete();
    exp_tail = pc & ~32'h3;
    exp_req  = exp_tail;
  endtask

  // One clock cycle of stimulus. mode: 0 none, 1 flush, 2 flush only if a
  // response is presented this cycle.
  task automatic step(input int mode, input logic [31:0] fpc, input bit do_rst);
    int pend_before;
    @(negedge clk);
    rst_ni          = !do_rst;
    flush_pc_i      = fpc;
    mem_req_ready_i = ($urandom_range(99, 0) < rdy_pct);
    instr_ready_i   = ($urandom_range(99, 0) < irdy_pct);
    if (do_rst) pend.delete();
    pend_before = pend.size();
    if (!do_rst && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = pend[0].addr ^ KEY;
      mem_rsp_err_i   = err_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = $urandom;
      mem_rsp_err_i   = 1'($urandom_range(1, 0));
    end
    flush_i     = !do_rst && ((mode == 1) || (mode == 2 && mem_rsp_valid_i));
    flushed_now = flush_i;
    #1;
    if (do_rst) begin
      if (rst_prev_low) begin
        chk_eq("rst_req_valid", 32'(mem_req_valid_o), 0);
        chk_eq("rst_req_addr", mem_req_addr_o, RV);
        chk_eq("rst_instr_valid", 32'(instr_valid_o), 0);
        chk_eq("rst_instr", instr_o, 0);
        chk_eq("rst_instr_pc", instr_pc_o, 0);
        chk_eq("rst_instr_err", 32'(instr_err_o), 0);
      end
      redirect_model(RV);
      restart  = 0;
      prev_vld = 0;
      rel_cnt  = 0;
    end else begin
      rel_cnt++;
      if (rel_cnt == 1) chk_eq("release_idle", 32'(mem_req_valid_o), 0);
      if (rel_cnt == 2 && !flush_i) begin
        chk_eq("release_first_req", 32'(mem_req_valid_o), 1);
        chk_eq("release_first_addr", mem_req_addr_o, RV);
      end
      if (prev_vld && !flush_i) begin
        chk_eq("req_hold_valid", 32'(mem_req_valid_o), 1);
        chk_eq("req_hold_addr", mem_req_addr_o, last_acc);
      end
      if (flush_i) begin
        chk_eq("flush_req_low", 32'(mem_req_valid_o), 0);
        redirect_model(fpc);
        restart = 1;
      end else if (restart && rel_cnt > 1) begin
        chk_eq("restart_req", 32'(mem_req_valid_o), 32'(pend_before == 0));
        if (pend_before == 0) restart = 0;
      end
      if (!flush_i && mem_req_valid_o && mem_req_ready_i) begin
        chk_eq("req_addr", mem_req_addr_o, exp_req);
        if (mem_req_addr_o == 32'h0 && last_acc == 32'hFFFF_FFFC) saw_wrap = 1;
        exp_req = exp_req + 32'd4;
        pend.push_back('{addr: mem_req_addr_o, due: cyc + $urandom_range(lat_max, lat_min)});
        accepts++;
        chk_eq("outstanding_limit", 32'(pend.size() > MAXO), 0);
      end
      prev_vld = mem_req_valid_o && !mem_req_ready_i;
      if (mem_req_valid_o) last_acc = mem_req_addr_o;
    end
    while (exp_q.size() < 32) begin
      exp_q.push_back(model_entry(exp_tail));
      exp_tail = exp_tail + 32'd4;
    end
    rst_prev_low = do_rst;
    cyc++;
  endtask

  // Monitor: pops the reference stream on every decode handshake.
  always @(negedge clk) begin
    fetch_entry_t e;
    #2;
    if (rst_ni) begin
      if (prev_flush_m) chk_eq("flush_clears_head", 32'(instr_valid_o), 0);
      if (instr_valid_o && instr_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_instr", instr_pc_o, 32'hDEAD_DEAD);
        end else begin
          e = exp_q.pop_front();
          chk_eq("instr_pc", instr_pc_o, e.pc);
          chk_eq("instr_data", instr_o, e.instr);
          chk_eq("instr_err", 32'(instr_err_o), 32'(e.err));
          pops++;
        end
      end
    end
    prev_flush_m = flush_i && rst_ni;
  end

  initial begin
    int p0, a0, n;
    bit hit;
    exp_req = RV; exp_tail = RV; last_acc = '0;
    // Reset and sequential fetch at full rate with 1-cycle memory.
    repeat (3) step(0, 0, 1);
    repeat (12) step(0, 0, 0);
    #5 p0 = pops;
    repeat (20) step(0, 0, 0);
    #5 chk_eq("throughput_20", 32'(pops - p0), 20);

    // Decode stalled: exactly DEPTH fetches after restarting at 0x0.
    irdy_pct = 0;
    step(1, 32'h0, 0);
    a0 = accepts;
    repeat (20) step(0, 0, 0);
    chk_eq("stall_fetch_count", 32'(accepts - a0), DEPTH);
    chk_eq("stall_no_req", 32'(mem_req_valid_o), 0);
    chk_eq("stall_head_valid", 32'(instr_valid_o), 1);
    irdy_pct = 100;
    repeat (15) step(0, 0, 0);

    // Two requests in flight (0x8, 0xC) when redirected to 0x103.
    lat_min = 8; lat_max = 8;
    step(1, 32'h8, 0);
    hit = 0; n = 0;
    while (!hit && n < 40) begin
      step(0, 0, 0);
      n++;
      if (pend.size() == 2 && pend[0].addr == 32'h8) hit = 1;
    end
    chk_eq("two_outstanding", 32'(hit), 1);
    step(1, 32'h103, 0);
    lat_min = 1; lat_max = 1;
    repeat (30) step(0, 0, 0);

    // Redirect in the same cycle as a response.
    lat_min = 2; lat_max = 2;
    hit = 0; n = 0;
    while (!hit && n < 20) begin
      step(2, 32'h200, 0);
      hit = flushed_now;
      n++;
    end
    chk_eq("flush_with_rsp", 32'(hit), 1);
    repeat (20) step(0, 0, 0);

    // Address wrap.
    lat_min = 1; lat_max = 1;
    step(1, 32'hFFFF_FFF4, 0);
    repeat (20) step(0, 0, 0);
    chk_eq("addr_wrap", 32'(saw_wrap), 1);

    // Random traffic with random redirects and a mid-run reset.
    rdy_pct = 70; irdy_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        repeat (3) step(0, 0, 1);
      end else if ($urandom_range(99, 0) < 3) begin
        step(1, $urandom, 0);
      end else begin
        step(0, 0, 0);
      end
    end
    rdy_pct = 100; irdy_pct = 100;
    repeat (20) step(0, 0, 0);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
